// File: rtl/wishbone_master_axis_burst.sv
// Byte-stream command parser driving single/burst Wishbone classic cycles.
// Responses (ACK, read data, status) return on an 8-bit AXI-Stream master.
module wishbone_master_axis_burst #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [7:0]              m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic                    wb_we_o,
    output logic                    wb_stb_o,
    output logic                    wb_cyc_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int AB = ADDR_WIDTH / 8;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD_ACK, S_ADDR, S_LEN, S_WDATA,
        S_WB, S_RDATA, S_DRAIN, S_STATUS
    } state_t;

    state_t                  state_q;
    logic                    wr_q;
    logic                    fix_q;
    logic                    bad_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [DATA_WIDTH-1:0]   rdat_q;
    logic [15:0]             len_q;
    logic [15:0]             cnt_q;
    logic [15:0]             to_q;
    logic [3:0]              bcnt_q;
    logic [7:0]              status_q;
    logic                    cyc_q;

    logic                    s_fire_d;
    logic [15:0]             len_d;
    logic [15:0]             cnt_inc_d;
    logic                    last_word_d;
    logic                    last_adr_byte_d;
    logic                    last_dat_byte_d;
    logic [7:0]              m_tdata_d;
    logic                    unused_tlast;

    assign unused_tlast = s_axis_tlast;

    assign s_axis_tready = rst_n && (state_q inside
        {S_IDLE, S_ADDR, S_LEN, S_WDATA, S_DRAIN});
    assign s_fire_d        = s_axis_tvalid && s_axis_tready;
    assign len_d           = {len_q[7:0], s_axis_tdata};
    assign cnt_inc_d       = cnt_q + 16'd1;
    assign last_word_d     = (cnt_inc_d == len_q);
    assign last_adr_byte_d = (bcnt_q == 4'(AB - 1));
    assign last_dat_byte_d = (bcnt_q == 4'(NB - 1));

    always_comb begin
        m_tdata_d = 8'h00;
        unique case (state_q)
            S_CMD_ACK: m_tdata_d = 8'hA5;
            S_RDATA:   m_tdata_d = rdat_q[DATA_WIDTH-1 -: 8];
            S_STATUS:  m_tdata_d = status_q;
            default:   m_tdata_d = 8'h00;
        endcase
    end

    assign m_axis_tdata  = m_tdata_d;
    assign m_axis_tvalid = state_q inside {S_CMD_ACK, S_RDATA, S_STATUS};
    assign m_axis_tlast  = (state_q == S_STATUS);

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = cyc_q && wr_q;
    assign wb_sel_o = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            fix_q    <= 1'b0;
            bad_q    <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            rdat_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            to_q     <= '0;
            bcnt_q   <= '0;
            status_q <= 8'h00;
            cyc_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: if (s_fire_d) begin
                    wr_q    <= s_axis_tdata[0];
                    fix_q   <= s_axis_tdata[1];
                    bad_q   <= |s_axis_tdata[7:2];
                    state_q <= S_CMD_ACK;
                end
                S_CMD_ACK: if (m_axis_tready) begin
                    bcnt_q <= '0;
                    if (bad_q) begin
                        status_q <= 8'hFD;
                        state_q  <= S_STATUS;
                    end else begin
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: if (s_fire_d) begin
                    adr_q <= (adr_q << 8) | ADDR_WIDTH'(s_axis_tdata);
                    if (last_adr_byte_d) begin
                        bcnt_q  <= '0;
                        state_q <= S_LEN;
                    end else begin
                        bcnt_q <= bcnt_q + 4'd1;
                    end
                end
                S_LEN: if (s_fire_d) begin
                    len_q <= len_d;
                    if (bcnt_q[0]) begin
                        bcnt_q <= '0;
                        cnt_q  <= '0;
                        if (len_d == 16'd0) begin
                            status_q <= 8'h01;
                            state_q  <= S_STATUS;
                        end else if (wr_q) begin
                            state_q <= S_WDATA;
                        end else begin
                            cyc_q   <= 1'b1;
                            to_q    <= '0;
                            state_q <= S_WB;
                        end
                    end else begin
                        bcnt_q <= 4'd1;
                    end
                end
                S_WDATA: if (s_fire_d) begin
                    dat_q <= (dat_q << 8) | DATA_WIDTH'(s_axis_tdata);
                    if (last_dat_byte_d) begin
                        bcnt_q  <= '0;
                        cyc_q   <= 1'b1;
                        to_q    <= '0;
                        state_q <= S_WB;
                    end else begin
                        bcnt_q <= bcnt_q + 4'd1;
                    end
                end
                S_WB: begin
                    // err outranks ack; timeout only when neither arrives
                    if (wb_err_i || (!wb_ack_i && to_q == TO_LAST)) begin
                        cyc_q    <= 1'b0;
                        cnt_q    <= cnt_inc_d;
                        status_q <= wb_err_i ? 8'hFF : 8'hFE;
                        if (wr_q && !last_word_d) begin
                            state_q <= S_DRAIN;
                        end else begin
                            state_q <= S_STATUS;
                        end
                    end else if (wb_ack_i) begin
                        cyc_q <= 1'b0;
                        cnt_q <= cnt_inc_d;
                        if (!fix_q) begin
                            adr_q <= adr_q + ADDR_WIDTH'(NB);
                        end
                        if (!wr_q) begin
                            rdat_q  <= wb_dat_i;
                            state_q <= S_RDATA;
                        end else if (last_word_d) begin
                            status_q <= 8'h01;
                            state_q  <= S_STATUS;
                        end else begin
                            state_q <= S_WDATA;
                        end
                    end else begin
                        to_q <= to_q + 16'd1;
                    end
                end
                S_RDATA: if (m_axis_tready) begin
                    rdat_q <= rdat_q << 8;
                    if (last_dat_byte_d) begin
                        bcnt_q <= '0;
                        if (cnt_q == len_q) begin
                            status_q <= 8'h01;
                            state_q  <= S_STATUS;
                        end else begin
                            cyc_q   <= 1'b1;
                            to_q    <= '0;
                            state_q <= S_WB;
                        end
                    end else begin
                        bcnt_q <= bcnt_q + 4'd1;
                    end
                end
                S_DRAIN: if (s_fire_d) begin
                    if (last_dat_byte_d) begin
                        bcnt_q <= '0;
                        cnt_q  <= cnt_inc_d;
                        if (last_word_d) begin
                            state_q <= S_STATUS;
                        end
                    end else begin
                        bcnt_q <= bcnt_q + 4'd1;
                    end
                end
                S_STATUS: if (m_axis_tready) begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_master_axis_burst.sv
// Scoreboard bench for wishbone_master_axis_burst (32-bit bus, 16-cycle timeout).
// Packet table drives expected bytes/bus cycles; hand sequences cover reset.
module tb_wishbone_master_axis_burst;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    s_axis_tdata = 8'h00;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_we_o, wb_stb_o, wb_cyc_o;
    logic [3:0]    wb_sel_o;
    logic          wb_ack_i, wb_err_i;

    always #5 clk = ~clk;

    wishbone_master_axis_burst #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Wishbone slave model
    int sl_n = 0, pkt_base = 0, sl_wait = 0, sl_err_at = -1;
    bit sl_never = 0, sl_both = 0;
    int wcnt = 0, cyc_run = 0, last_run = 0, cyc_rises = 0;
    logic cyc_prev = 1'b0;
    logic err_hit;

    assign err_hit  = (sl_n - pkt_base) == sl_err_at;
    assign wb_ack_i = wb_cyc_o && wb_stb_o && !sl_never && (wcnt >= sl_wait)
                      && (!err_hit || sl_both);
    assign wb_err_i = wb_cyc_o && wb_stb_o && err_hit && (wcnt >= sl_wait);
    assign wb_dat_i = 32'hA0000001 + 32'(sl_n - pkt_base);

    always @(posedge clk) begin
        cyc_prev <= wb_cyc_o;
        if (wb_cyc_o && !cyc_prev) cyc_rises <= cyc_rises + 1;
        if (wb_cyc_o) begin
            wcnt    <= wcnt + 1;
            cyc_run <= cyc_run + 1;
        end else begin
            wcnt <= 0;
            if (cyc_run != 0) last_run <= cyc_run;
            cyc_run <= 0;
        end
        if (wb_cyc_o && (wb_ack_i || wb_err_i)) sl_n <= sl_n + 1;
    end

    // Scoreboard queues
    typedef struct packed { logic [7:0] b; logic l; } rbyte_t;
    typedef struct packed { logic [31:0] adr; logic we; logic [31:0] dat; logic err; } bus_t;
    rbyte_t rq[$];
    bus_t   bq[$];

    logic [7:0] hold_d = 8'h00;
    logic       hold_l = 1'b0;
    bit         stalled = 0;

    always @(negedge clk) begin
        rbyte_t er;
        bus_t   eb;
        if (!rst_n) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                check("hold_valid", 64'(m_axis_tvalid), 64'd1);
                check("hold_data", 64'(m_axis_tdata), 64'(hold_d));
                check("hold_last", 64'(m_axis_tlast), 64'(hold_l));
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            hold_d  = m_axis_tdata;
            hold_l  = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                if (rq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL resp_extra: got %02h, expected no byte", m_axis_tdata);
                end else begin
                    er = rq.pop_front();
                    check("resp_byte", 64'(m_axis_tdata), 64'(er.b));
                    check("resp_last", 64'(m_axis_tlast), 64'(er.l));
                end
            end
            if (wb_cyc_o && (wb_ack_i || wb_err_i)) begin
                if (bq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL bus_extra: got adr %08h, expected no cycle", wb_adr_o);
                end else begin
                    eb = bq.pop_front();
                    check("bus_adr", 64'(wb_adr_o), 64'(eb.adr));
                    check("bus_we", 64'(wb_we_o), 64'(eb.we));
                    check("bus_err", 64'(wb_err_i), 64'(eb.err));
                    check("bus_sel", 64'(wb_sel_o), 64'hF);
                    if (eb.we) check("bus_dat", 64'(wb_dat_o), 64'(eb.dat));
                end
            end
        end
    end

    // Stream drivers
    bit bp = 0;
    bit gaps = 0;

    initial forever begin
        @(posedge clk);
        #1;
        m_axis_tready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    task automatic send_byte(input logic [7:0] b);
        int  budget;
        bit  done;
        budget = 0;
        done   = 0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            s_axis_tvalid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b;
        while (!done) begin
            @(negedge clk);
            if (s_axis_tready) begin
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                budget++;
                if (budget > 300) begin
                    n_cmp++; n_bad++;
                    $display("FAIL send_timeout: byte %02h not accepted, expected accept", b);
                    done = 1;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (!(rq.size() == 0 && bq.size() == 0 && s_axis_tready
                 && !m_axis_tvalid && !wb_cyc_o) && budget < 3000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        n_cmp++;
        if (budget >= 3000) begin
            n_bad++;
            $display("FAIL idle_timeout: %0d bytes and %0d cycles pending, expected 0",
                     rq.size(), bq.size());
        end
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] adr;
        logic [15:0] len;
        logic [31:0] wd;
        int          wt;
        int          err_at;
        bit          never;
        bit          both;
        logic [7:0]  st;
    } vec_t;

    task automatic run_vec(input vec_t v);
        bit          wr, fx, bad;
        int          fail_at, nok, rises0;
        logic [31:0] a, d, rv;
        wr      = v.cmd[0];
        fx      = v.cmd[1];
        bad     = v.cmd[7:2] != 6'd0;
        fail_at = v.never ? 0 : v.err_at;
        nok     = (fail_at < 0 || fail_at >= int'(v.len)) ? int'(v.len) : fail_at;
        rises0  = cyc_rises;
        sl_wait   = v.wt;
        sl_err_at = v.err_at;
        sl_never  = v.never;
        sl_both   = v.both;
        pkt_base  = sl_n;
        rq.push_back({8'hA5, 1'b0});
        if (bad) begin
            rq.push_back({v.st, 1'b1});
            send_byte(v.cmd);
        end else begin
            for (int w = 0; w < int'(v.len); w++) begin
                a = fx ? v.adr : v.adr + 32'(4 * w);
                d = v.wd + 32'h44444444 * 32'(w);
                if (w < nok || (w == fail_at && !v.never))
                    bq.push_back({a, wr, d, 1'(w == fail_at)});
                if (!wr && w < nok) begin
                    rv = 32'hA0000001 + 32'(w);
                    for (int k = 3; k >= 0; k--) rq.push_back({rv[8*k +: 8], 1'b0});
                end
            end
            rq.push_back({v.st, 1'b1});
            send_byte(v.cmd);
            for (int k = 3; k >= 0; k--) send_byte(v.adr[8*k +: 8]);
            send_byte(v.len[15:8]);
            send_byte(v.len[7:0]);
            if (wr) begin
                for (int w = 0; w < int'(v.len); w++) begin
                    d = v.wd + 32'h44444444 * 32'(w);
                    for (int k = 3; k >= 0; k--) send_byte(d[8*k +: 8]);
                end
            end
        end
        wait_idle();
        if (v.never) check("timeout_cyc_len", 64'(last_run), 64'(TO));
        if (bad || v.len == 16'd0) check("no_cyc", 64'(cyc_rises), 64'(rises0));
    endtask

    vec_t tbl[14];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'h01, 32'h00001000, 16'd2, 32'h11223344, 0, -1, 0, 0, 8'h01};
        tbl[1]  = '{8'h00, 32'h00002000, 16'd3, 32'h0,        0, -1, 0, 0, 8'h01};
        tbl[2]  = '{8'h03, 32'h00000020, 16'd4, 32'h0BAD0001, 0, -1, 0, 0, 8'h01};
        tbl[3]  = '{8'h01, 32'h00004000, 16'd3, 32'hC0FFEE00, 0, -1, 1, 0, 8'hFE};
        tbl[4]  = '{8'h00, 32'h00005000, 16'd4, 32'h0,        1,  1, 0, 0, 8'hFF};
        tbl[5]  = '{8'h80, 32'h0,        16'd0, 32'h0,        0, -1, 0, 0, 8'hFD};
        tbl[6]  = '{8'h01, 32'h00006000, 16'd0, 32'h0,        0, -1, 0, 0, 8'h01};
        tbl[7]  = '{8'h02, 32'h00007000, 16'd2, 32'h0,        2, -1, 0, 0, 8'h01};
        tbl[8]  = '{8'h01, 32'h00008000, 16'd2, 32'h12345678, 0,  0, 0, 1, 8'hFF};
        tbl[9]  = '{8'h00, 32'h00009000, 16'd2, 32'h0,        0, -1, 1, 0, 8'hFE};
        tbl[10] = '{8'h01, 32'hFFFFFFFC, 16'd2, 32'hDEADBEEF, 1, -1, 0, 0, 8'h01};
        tbl[11] = '{8'h00, 32'h0000A000, 16'd2, 32'h0,        0,  0, 0, 1, 8'hFF};
        tbl[12] = '{8'h04, 32'h0,        16'd0, 32'h0,        0, -1, 0, 0, 8'hFD};
        tbl[13] = '{8'h01, 32'h0000B000, 16'd2, 32'h01020304, 0,  1, 0, 0, 8'hFF};

        #1;
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_cyc", 64'(wb_cyc_o), 64'd0);
        check("rst_stb", 64'(wb_stb_o), 64'd0);
        check("rst_we", 64'(wb_we_o), 64'd0);
        check("rst_sel", 64'(wb_sel_o), 64'hF);
        check("rst_adr", 64'(wb_adr_o), 64'd0);
        check("rst_dat", 64'(wb_dat_o), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_s_tready", 64'(s_axis_tready), 64'd1);

        for (int p = 0; p < 2; p++) begin
            bp   = (p == 1);
            gaps = (p == 1);
            for (int i = 0; i < 14; i++) run_vec(tbl[i]);
        end

        // reset pulsed while a read burst is on the bus
        bp = 0;
        gaps = 0;
        begin
            int budget;
            sl_wait   = 6;
            sl_err_at = -1;
            sl_never  = 0;
            sl_both   = 0;
            pkt_base  = sl_n;
            rq.push_back({8'hA5, 1'b0});
            send_byte(8'h00);
            for (int k = 0; k < 4; k++) send_byte(8'h30);
            send_byte(8'h00);
            send_byte(8'h04);
            budget = 0;
            while (!wb_cyc_o && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            check("rst_mid_cyc_seen", 64'(wb_cyc_o), 64'd1);
            #2;
            rst_n = 1'b0;
            #1;
            check("rst_mid_cyc", 64'(wb_cyc_o), 64'd0);
            check("rst_mid_stb", 64'(wb_stb_o), 64'd0);
            check("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
            rq.delete();
            bq.delete();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            run_vec(tbl[1]);
            run_vec(tbl[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
